// File: rtl/page_walk_arbiter.sv
// One page table walk engine: round-robin grant, wait for completion or timeout, one response cycle.
// Grant registered one edge after the request is sampled; walks take 3 or more cycles; busy clients are skipped.
module pw_engine #(
   parameter int NUM_CLIENTS    = 2,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int LW             = 6
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CLIENTS-1:0]         elig,
   input  logic [LW-1:0]                  vpn [NUM_CLIENTS],
   input  logic                           complete,
   output logic                           grant,
   output logic [$clog2(NUM_CLIENTS)-1:0] pick,
   output logic                           fin_ok,
   output logic                           fin_to,
   output logic                           resp,
   output logic [$clog2(NUM_CLIENTS)-1:0] owner,
   output logic                           rqst,
   output logic [LW-1:0]                  lookup
);
   localparam int CW = $clog2(NUM_CLIENTS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   last_q;
   logic [CW-1:0]   cand;
   logic [7:0]      timer_q;
   logic            found;

   // Rotating search starting just after the previous winner.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int j = 1; j <= NUM_CLIENTS; j++) begin
         cand = CW'((int'(last_q) + j) % NUM_CLIENTS);
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      fin_ok  = 1'b0;
      fin_to  = 1'b0;
      resp    = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant   = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (complete) begin
               fin_ok  = 1'b1;
               state_d = RESP;
            end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
               fin_to  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= CW'(NUM_CLIENTS - 1);
         owner   <= '0;
         timer_q <= '0;
         rqst    <= 1'b0;
         lookup  <= '0;
      end else begin
         state_q <= state_d;
         rqst    <= grant;
         if (grant) begin
            owner   <= pick;
            last_q  <= pick;
            timer_q <= '0;
            lookup  <= vpn[pick];
         end else if (state_q == WAIT) begin
            timer_q <= timer_q + 8'd1;
         end
         if (fin_ok || fin_to) begin
            lookup <= '0;
         end
      end
   end
endmodule

// Shares the 8-byte and 32-byte page table ports among TLB clients with two concurrent walk engines.
// All outputs registered; a client holding its request after grant is not re-granted until its walk completes.
module page_walk_arbiter #(
   parameter int NUM_CLIENTS    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CLIENTS-1:0]    CLI_RQST,
   input  logic [NUM_CLIENTS-1:0]    CLI_SIZE,
   input  logic [6*NUM_CLIENTS-1:0]  CLI_VPN,
   output logic [NUM_CLIENTS-1:0]    CLI_GRANT,
   output logic [NUM_CLIENTS-1:0]    CLI_DONE,
   output logic [NUM_CLIENTS-1:0]    CLI_ERR,
   output logic [12*NUM_CLIENTS-1:0] CLI_DATA,
   output logic                      PAGE_8B_RQST,
   output logic [5:0]                PAGE_8B_LOOKUP,
   input  logic [11:0]               PAGE_8B_RECV,
   input  logic                      PAGE_8B_COMPLETE,
   output logic                      PAGE_32B_RQST,
   output logic [3:0]                PAGE_32B_LOOKUP,
   input  logic [7:0]                PAGE_32B_RECV,
   input  logic                      PAGE_32B_COMPLETE
);
   localparam int CW = $clog2(NUM_CLIENTS);

   logic [5:0]             vpn8  [NUM_CLIENTS];
   logic [3:0]             vpn32 [NUM_CLIENTS];
   logic [11:0]            data_q [NUM_CLIENTS];
   logic [NUM_CLIENTS-1:0] busy_q, elig8, elig32, grant_q, done_q, err_q;

   logic          e8_grant, e8_ok, e8_to, e8_resp;
   logic          e32_grant, e32_ok, e32_to, e32_resp;
   logic [CW-1:0] e8_pick, e8_owner, e32_pick, e32_owner;

   for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cli
      assign vpn8[i]  = CLI_VPN[6*i +: 6];
      assign vpn32[i] = CLI_VPN[6*i+2 +: 4];
      assign CLI_DATA[12*i +: 12] = data_q[i];
   end

   assign elig8     = CLI_RQST & ~CLI_SIZE & ~busy_q;
   assign elig32    = CLI_RQST &  CLI_SIZE & ~busy_q;
   assign CLI_GRANT = grant_q;
   assign CLI_DONE  = done_q;
   assign CLI_ERR   = err_q;

   pw_engine #(.NUM_CLIENTS(NUM_CLIENTS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LW(6)) u_e8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .elig     (elig8),
      .vpn      (vpn8),
      .complete (PAGE_8B_COMPLETE),
      .grant    (e8_grant),
      .pick     (e8_pick),
      .fin_ok   (e8_ok),
      .fin_to   (e8_to),
      .resp     (e8_resp),
      .owner    (e8_owner),
      .rqst     (PAGE_8B_RQST),
      .lookup   (PAGE_8B_LOOKUP)
   );

   pw_engine #(.NUM_CLIENTS(NUM_CLIENTS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LW(4)) u_e32 (
      .clk      (clk),
      .rst_n    (rst_n),
      .elig     (elig32),
      .vpn      (vpn32),
      .complete (PAGE_32B_COMPLETE),
      .grant    (e32_grant),
      .pick     (e32_pick),
      .fin_ok   (e32_ok),
      .fin_to   (e32_to),
      .resp     (e32_resp),
      .owner    (e32_owner),
      .rqst     (PAGE_32B_RQST),
      .lookup   (PAGE_32B_LOOKUP)
   );

   // A client is busy in at most one engine, so the two engines never touch the same bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         busy_q  <= '0;
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         if (e8_grant) begin
            grant_q[e8_pick] <= 1'b1;
            busy_q[e8_pick]  <= 1'b1;
         end
         if (e32_grant) begin
            grant_q[e32_pick] <= 1'b1;
            busy_q[e32_pick]  <= 1'b1;
         end
         if (e8_ok || e8_to) begin
            done_q[e8_owner] <= 1'b1;
            err_q[e8_owner]  <= e8_to;
            data_q[e8_owner] <= e8_ok ? PAGE_8B_RECV : 12'h000;
         end
         if (e32_ok || e32_to) begin
            done_q[e32_owner] <= 1'b1;
            err_q[e32_owner]  <= e32_to;
            data_q[e32_owner] <= e32_ok ? {4'h0, PAGE_32B_RECV} : 12'h000;
         end
         if (e8_resp) begin
            busy_q[e8_owner] <= 1'b0;
         end
         if (e32_resp) begin
            busy_q[e32_owner] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_page_walk_arbiter.sv
// Randomized and directed check of page_walk_arbiter against a timestamp-based reference model.
module tb_page_walk_arbiter;
   localparam int NC = 3;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NC-1:0]    rq = '0, sz = '0;
   logic [6*NC-1:0]  vpn = '0;
   logic             comp8 = 1'b0, comp32 = 1'b0;
   logic [11:0]      recv8 = '0;
   logic [7:0]       recv32 = '0;

   logic [NC-1:0]    grant, done, err;
   logic [12*NC-1:0] data;
   logic             rq8o, rq32o;
   logic [5:0]       look8;
   logic [3:0]       look32;

   always #5 clk = ~clk;

   page_walk_arbiter #(.NUM_CLIENTS(NC), .TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .CLI_RQST          (rq),
      .CLI_SIZE          (sz),
      .CLI_VPN           (vpn),
      .CLI_GRANT         (grant),
      .CLI_DONE          (done),
      .CLI_ERR           (err),
      .CLI_DATA          (data),
      .PAGE_8B_RQST      (rq8o),
      .PAGE_8B_LOOKUP    (look8),
      .PAGE_8B_RECV      (recv8),
      .PAGE_8B_COMPLETE  (comp8),
      .PAGE_32B_RQST     (rq32o),
      .PAGE_32B_LOOKUP   (look32),
      .PAGE_32B_RECV     (recv32),
      .PAGE_32B_COMPLETE (comp32)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: each engine is free, walking since edge m_k, or responding.
   int            t;
   int            m_phase [2];
   int            m_owner [2];
   int            m_k     [2];
   int            m_last  [2];
   bit [NC-1:0]   m_busy;
   logic [NC-1:0] exp_grant, exp_done, exp_err;
   logic [1:0]    exp_rq;
   int            exp_look [2];
   int            exp_data [NC];

   task automatic model_reset();
      t = 0;
      m_busy = '0;
      exp_grant = '0; exp_done = '0; exp_err = '0; exp_rq = '0;
      for (int e = 0; e < 2; e++) begin
         m_phase[e] = 0; m_owner[e] = 0; m_k[e] = 0; m_last[e] = NC - 1; exp_look[e] = 0;
      end
   endtask

   task automatic model_edge();
      bit [NC-1:0] busy_pre;
      bit          cmp, got;
      int          c;
      exp_grant = '0; exp_done = '0; exp_err = '0; exp_rq = '0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      t++;
      busy_pre = m_busy;
      for (int e = 0; e < 2; e++) begin
         cmp = (e == 0) ? comp8 : comp32;
         if (m_phase[e] == 1) begin
            if (cmp || (t - m_k[e] == TO)) begin
               c = m_owner[e];
               exp_done[c] = 1'b1;
               exp_err[c]  = !cmp;
               exp_data[c] = !cmp ? 0 : (e == 0 ? int'(recv8) : int'(recv32));
               exp_look[e] = 0;
               m_phase[e]  = 2;
            end
         end else if (m_phase[e] == 2) begin
            m_busy[m_owner[e]] = 1'b0;
            m_phase[e] = 0;
         end else begin
            got = 1'b0;
            for (int j = 1; j <= NC; j++) begin
               c = (m_last[e] + j) % NC;
               if (!got && rq[c] && (int'(sz[c]) == e) && !busy_pre[c]) begin
                  got = 1'b1;
                  m_owner[e] = c; m_last[e] = c; m_k[e] = t; m_phase[e] = 1;
                  m_busy[c] = 1'b1;
                  exp_grant[c] = 1'b1;
                  exp_rq[e] = 1'b1;
                  exp_look[e] = (e == 0) ? int'(vpn[6*c +: 6]) : int'(vpn[6*c+2 +: 4]);
               end
            end
         end
      end
   endtask

   task automatic compare();
      chk("grant", grant, exp_grant);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      chk("rqst8", rq8o, exp_rq[0]);
      chk("rqst32", rq32o, exp_rq[1]);
      chk("lookup8", look8, exp_look[0]);
      chk("lookup32", look32, exp_look[1]);
      for (int i = 0; i < NC; i++) begin
         if (exp_done[i]) chk("data", data[12*i +: 12], exp_data[i]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic set_req(input int c, input bit s, input logic [5:0] v);
      rq[c] = 1'b1; sz[c] = s; vpn[6*c +: 6] = v;
   endtask

   int order [3];
   int ng;

   initial begin
      model_reset();
      for (int i = 0; i < NC; i++) exp_data[i] = 0;
      // Reset state
      step(); step();
      chk("rst_grant", grant, 0);
      chk("rst_data", data, 0);
      rst_n = 1'b1;
      step();

      // Single 8B walk, completion three cycles after the page table request
      set_req(0, 1'b0, 6'h2A);
      step();
      chk("t1_grant", grant, 3'b001);
      chk("t1_rqst8", rq8o, 1);
      rq[0] = 1'b0;
      step();
      chk("t1_look_a", look8, 6'h2A);
      step();
      chk("t1_look_b", look8, 6'h2A);
      comp8 = 1'b1; recv8 = 12'hABC;
      step();
      chk("t1_done", done, 3'b001);
      chk("t1_data", data[11:0], 12'hABC);
      chk("t1_err", err, 0);
      comp8 = 1'b0;
      step(); step();

      // Round robin on the 32B engine between clients 0 and 1
      set_req(0, 1'b1, 6'h3C);
      set_req(1, 1'b1, 6'h17);
      comp32 = 1'b1; recv32 = 8'h5E;
      ng = 0;
      for (int c = 0; c < 40 && ng < 3; c++) begin
         step();
         if (grant[0]) begin order[ng] = 0; ng++; end
         else if (grant[1]) begin order[ng] = 1; ng++; end
      end
      chk("rr_count", ng, 3);
      chk("rr_first", order[0], 0);
      chk("rr_second", order[1], 1);
      chk("rr_third", order[2], 0);
      rq = '0;
      step(); step(); step();
      comp32 = 1'b0;
      step(); step();

      // Concurrent 8B and 32B walks finishing together
      set_req(0, 1'b0, 6'h11);
      set_req(1, 1'b1, 6'h24);
      step();
      chk("cc_grant", grant, 3'b011);
      chk("cc_rqst", {rq32o, rq8o}, 2'b11);
      rq = '0;
      step();
      comp8 = 1'b1; recv8 = 12'h123; comp32 = 1'b1; recv32 = 8'hC4;
      step();
      chk("cc_done", done, 3'b011);
      chk("cc_data32", data[23:12], 12'h0C4);
      comp8 = 1'b0; comp32 = 1'b0;
      step(); step();

      // Timeout, then a late completion that must be dropped
      set_req(2, 1'b0, 6'h09);
      step();
      chk("to_grant", grant, 3'b100);
      rq[2] = 1'b0;
      repeat (3) step();
      chk("to_early", done, 0);
      step();
      chk("to_done", done[2], 1);
      chk("to_err", err[2], 1);
      chk("to_data", data[35:24], 0);
      step();
      comp8 = 1'b1; recv8 = 12'hFFF;
      step();
      chk("to_late", done, 0);
      comp8 = 1'b0;
      step();

      // Completion on the expiry cycle wins over timeout
      set_req(2, 1'b0, 6'h30);
      step();
      rq[2] = 1'b0;
      repeat (3) step();
      comp8 = 1'b1; recv8 = 12'h5A5;
      step();
      chk("tie_done", done[2], 1);
      chk("tie_err", err[2], 0);
      chk("tie_data", data[35:24], 12'h5A5);
      comp8 = 1'b0;
      step(); step();

      // Held request is not re-granted until the walk completes
      set_req(0, 1'b0, 6'h05);
      step();
      chk("busy_grant", grant[0], 1);
      step();
      chk("busy_hold_a", grant[0], 0);
      comp8 = 1'b1;
      step();
      chk("busy_done", done[0], 1);
      chk("busy_hold_b", grant[0], 0);
      comp8 = 1'b0;
      step();
      chk("busy_hold_c", grant[0], 0);
      step();
      chk("busy_regrant", grant[0], 1);
      rq[0] = 1'b0;
      comp8 = 1'b1;
      step(); step();
      comp8 = 1'b0;
      step(); step();

      // Reset in the middle of a walk
      set_req(1, 1'b0, 6'h15);
      step();
      rq[1] = 1'b0;
      step();
      chk("rw_look", look8, 6'h15);
      rst_n = 1'b0;
      #1;
      chk("rw_look0", look8, 0);
      chk("rw_outs", {grant, done, err, rq8o, rq32o}, 0);
      chk("rw_data", data, 0);
      model_reset();
      step();
      comp8 = 1'b1;
      rst_n = 1'b1;
      step();
      chk("rw_ignore", done, 0);
      comp8 = 1'b0;
      set_req(0, 1'b0, 6'h01);
      set_req(1, 1'b0, 6'h02);
      step();
      chk("rw_first", grant, 3'b001);
      rq = '0;
      comp8 = 1'b1;
      step(); step(); step(); step();
      comp8 = 1'b0;
      step(); step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NC; i++) begin
            if (rq[i] && grant[i] && ($urandom_range(1, 0) == 1)) rq[i] = 1'b0;
            else if (!rq[i] && ($urandom_range(3, 0) == 0)) begin
               set_req(i, 1'($urandom_range(1, 0)), 6'($urandom));
            end
         end
         comp8  = ($urandom_range(2, 0) == 0);
         comp32 = ($urandom_range(2, 0) == 0);
         recv8  = 12'($urandom);
         recv32 = 8'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
